// File: rtl/rgmii_speed_ctrl.sv
// RGMII in-band status decoder, glitch-free speed-change sequencer and TX clock pattern generator.
// Optional build macro RGMII_SPEED_FORCE_EN: force_en/speed_force override the in-band speed request.
module rgmii_speed_ctrl #(
    parameter int DIV_10M    = 50,
    parameter int DIV_100M   = 5,
    parameter int STABLE_CNT = 16,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_d,
    input  logic       rx_dv,
    input  logic       rx_er,
    input  logic       rx_valid,
    input  logic       tx_busy,
    input  logic       force_en,
    input  logic [1:0] speed_force,
    output logic       link_up,
    output logic       full_duplex,
    output logic [1:0] speed,
    output logic       speed_change,
    output logic       tx_clk_1,
    output logic       tx_clk_2,
    output logic       tx_clk_en,
    output logic       tx_clk_rise,
    output logic       tx_clk_fall,
    output logic [1:0] fsm_state
);

    localparam int MATCH_W = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
    localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0]   LAST_10M  = CNT_W'(DIV_10M - 1);
    localparam logic [CNT_W-1:0]   MID_10M   = CNT_W'((DIV_10M - 1) / 2);
    localparam logic [CNT_W-1:0]   LAST_100M = CNT_W'(DIV_100M - 1);
    localparam logic [CNT_W-1:0]   MID_100M  = CNT_W'((DIV_100M - 1) / 2);
    localparam logic ODD_10M  = (DIV_10M % 2) != 0;
    localparam logic ODD_100M = (DIV_100M % 2) != 0;
    localparam logic [1:0] SPD_10M   = 2'b00;
    localparam logic [1:0] SPD_1000M = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SWITCH  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [3:0]           cand;
    logic [MATCH_W-1:0]   match_cnt;
    logic [1:0]           target;
    logic [CNT_W-1:0]     div_cnt;
    logic                 sample_ok;
    logic                 commit;
    logic                 req_valid;
    logic [1:0]           req_speed;
    logic                 switch_now;
    logic                 load_target;
    logic                 div_gig;
    logic [CNT_W-1:0]     div_last;
    logic [CNT_W-1:0]     div_mid;
    logic                 div_odd;
    logic                 unused_bits;

    // rx_valid is a qualify-only strobe with no backpressure; a status sample is a valid idle cycle.
    assign sample_ok = rx_valid && !rx_dv && !rx_er && (rx_d[2:1] != 2'b11);
    assign commit    = (match_cnt == MATCH_MAX);
    assign fsm_state = state;

`ifdef RGMII_SPEED_FORCE_EN
    assign unused_bits = ^rx_d[7:4];
`else
    assign unused_bits = ^{rx_d[7:4], force_en, speed_force};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand      <= '0;
            match_cnt <= '0;
        end else if (sample_ok) begin
            if (rx_d[3:0] != cand) begin
                cand      <= rx_d[3:0];
                match_cnt <= '0;
            end else if (match_cnt != MATCH_MAX) begin
                match_cnt <= match_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            link_up     <= 1'b0;
            full_duplex <= 1'b0;
        end else if (commit) begin
            link_up     <= cand[0];
            full_duplex <= cand[3];
        end
    end

    always_comb begin
        req_valid = commit && cand[0];
        req_speed = cand[2:1];
`ifdef RGMII_SPEED_FORCE_EN
        if (force_en) begin
            req_valid = 1'b1;
            req_speed = (speed_force == 2'b11) ? SPD_1000M : speed_force;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid && (req_speed != speed)) state_nxt = PENDING;
            end
            PENDING: begin
                if (req_valid && (req_speed == speed))  state_nxt = IDLE;
                else if (!tx_busy && tx_clk_fall)       state_nxt = SWITCH;
            end
            SWITCH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        switch_now  = (state == SWITCH);
        load_target = 1'b0;
        if ((state == IDLE) || (state == PENDING))
            load_target = req_valid && (req_speed != speed);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            speed        <= SPD_1000M;
            target       <= SPD_1000M;
            speed_change <= 1'b0;
        end else begin
            speed_change <= switch_now;
            if (switch_now)  speed  <= target;
            if (load_target) target <= req_speed;
        end
    end

    // 2'b11 is never committed; speed[1] alone selects the 1000M pattern.
    always_comb begin
        div_gig  = speed[1];
        div_last = (speed == SPD_10M) ? LAST_10M : LAST_100M;
        div_mid  = (speed == SPD_10M) ? MID_10M  : MID_100M;
        div_odd  = (speed == SPD_10M) ? ODD_10M  : ODD_100M;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt     <= '0;
            tx_clk_1    <= 1'b1;
            tx_clk_2    <= 1'b0;
            tx_clk_en   <= 1'b1;
            tx_clk_rise <= 1'b1;
            tx_clk_fall <= 1'b1;
        end else begin
            if (switch_now || div_gig || (div_cnt == div_last)) div_cnt <= '0;
            else                                                div_cnt <= div_cnt + 1'b1;

            if (div_gig) begin
                tx_clk_1    <= 1'b1;
                tx_clk_2    <= 1'b0;
                tx_clk_en   <= 1'b1;
                tx_clk_rise <= 1'b1;
                tx_clk_fall <= 1'b1;
            end else if (div_cnt == div_mid) begin
                tx_clk_1    <= 1'b1;
                tx_clk_2    <= 1'b1;
                tx_clk_en   <= 1'b0;
                tx_clk_rise <= 1'b1;
                tx_clk_fall <= 1'b0;
            end else if (div_cnt == div_last) begin
                // Odd divisors keep d1 high so the ODDR output splits the period on a half cycle.
                tx_clk_1    <= div_odd;
                tx_clk_2    <= 1'b0;
                tx_clk_en   <= 1'b1;
                tx_clk_rise <= 1'b0;
                tx_clk_fall <= 1'b1;
            end else begin
                tx_clk_1    <= tx_clk_2;
                tx_clk_en   <= 1'b0;
                tx_clk_rise <= 1'b0;
                tx_clk_fall <= 1'b0;
            end
        end
    end

endmodule
